// File: rtl/rr_lock_arbiter_pkg.sv
// rr_lock_arbiter_pkg: shared state type and one-hot decode helper for the lock arbiter
package rr_lock_arbiter_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  function automatic logic [4:0] onehot2bin(input logic [31:0] v);
    logic [4:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) if (v[i]) b |= 5'(i);
    return b;
  endfunction
endpackage

// File: rtl/rr_lock_arbiter_if.sv
// rr_lock_arbiter_if: request/grant bundle between requesters and the arbiter
interface rr_lock_arbiter_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] last;
  logic rr_en;
  logic [WIDTH-1:0] grant;
  logic [$clog2(WIDTH)-1:0] grant_id;
  logic grant_vld;
  modport master (output req, last, rr_en, input grant, grant_id, grant_vld);
  modport slave (input req, last, rr_en, output grant, grant_id, grant_vld);
endinterface

// File: rtl/rr_lock_arbiter_arbiter.sv
// rr_lock_arbiter_arbiter: fixed-priority pick, lowest set index wins
module rr_lock_arbiter_arbiter #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);
  assign gnt = req & (~req + WIDTH'(1));
endmodule

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: registered fixed/round-robin arbiter with grant locking and hold limit
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic rst_n,
  rr_lock_arbiter_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  state_e state;
  logic [WIDTH-1:0] grant, cand, hi, pick_hi, pick_all, winner, mask;
  logic [IW-1:0] ptr, grant_id, win_id;
  logic [HW-1:0] hold_cnt;
  logic grant_vld, rel, timeout, arb;
  assign timeout = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
  assign rel = (state == GRANT) && (~|(bus.req & grant) || |(bus.req & bus.last & grant) || timeout);
  assign arb = (state == IDLE) || rel;
  assign cand = bus.req & ~(rel ? grant : '0);
  assign mask = ~((WIDTH'(1) << ptr) - WIDTH'(1));
  assign hi = cand & mask;
  rr_lock_arbiter_arbiter #(.WIDTH(WIDTH)) u_hi (.req(hi), .gnt(pick_hi));
  rr_lock_arbiter_arbiter #(.WIDTH(WIDTH)) u_all (.req(cand), .gnt(pick_all));
  assign winner = (bus.rr_en && |hi) ? pick_hi : pick_all;
  assign win_id = IW'(onehot2bin(32'(winner)));
  assign bus.grant = grant;
  assign bus.grant_id = grant_id;
  assign bus.grant_vld = grant_vld;
  // lock the owner until release, then hand over in the same cycle without a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      grant_vld <= 1'b0;
      ptr <= '0;
      hold_cnt <= '0;
    end else if (arb) begin
      grant <= winner;
      grant_vld <= |cand;
      state <= |cand ? GRANT : IDLE;
      if (|cand) begin
        grant_id <= win_id;
        ptr <= (win_id == IW'(WIDTH - 1)) ? '0 : win_id + IW'(1);
        hold_cnt <= HW'(1);
      end
    end else begin
      hold_cnt <= &hold_cnt ? hold_cnt : hold_cnt + HW'(1);
    end
  end
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: directed and random checks of two arbiters (hold limit 4 and unlimited)
module tb_rr_lock_arbiter;
  localparam int W = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic [W-1:0] req = '0;
  logic [W-1:0] last = '0;
  logic rr_en = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int m_owner[2];
  int m_hold[2];
  int m_ptr[2];
  int m_id[2];
  int mh[2] = '{4, 0};
  always #5 clk = ~clk;
  rr_lock_arbiter_if #(.WIDTH(W)) b0 ();
  rr_lock_arbiter_if #(.WIDTH(W)) b1 ();
  assign b0.req = req;
  assign b0.last = last;
  assign b0.rr_en = rr_en;
  assign b1.req = req;
  assign b1.last = last;
  assign b1.rr_en = rr_en;
  rr_lock_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  rr_lock_arbiter #(.WIDTH(W), .MAX_HOLD(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_hold[d] = 0;
      m_ptr[d] = 0;
      m_id[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit rl;
      int ex, w, idx;
      rl = 0;
      if (m_owner[d] >= 0)
        rl = !req[m_owner[d]] || last[m_owner[d]] || (mh[d] != 0 && m_hold[d] == mh[d]);
      if (m_owner[d] < 0 || rl) begin
        ex = rl ? m_owner[d] : -1;
        w = -1;
        for (int k = 0; k < W; k++) begin
          idx = rr_en ? (m_ptr[d] + k) % W : k;
          if (w < 0 && req[idx] && idx != ex) w = idx;
        end
        m_owner[d] = w;
        if (w >= 0) begin
          m_hold[d] = 1;
          m_ptr[d] = (w + 1) % W;
          m_id[d] = w;
        end
      end else m_hold[d]++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grant0"}, 32'(b0.grant), m_owner[0] < 0 ? 0 : (1 << m_owner[0]));
    chk({tag, ".id0"}, 32'(b0.grant_id), m_id[0]);
    chk({tag, ".vld0"}, 32'(b0.grant_vld), m_owner[0] >= 0);
    chk({tag, ".grant1"}, 32'(b1.grant), m_owner[1] < 0 ? 0 : (1 << m_owner[1]));
    chk({tag, ".id1"}, 32'(b1.grant_id), m_id[1]);
    chk({tag, ".vld1"}, 32'(b1.grant_vld), m_owner[1] >= 0);
  endtask

  task automatic cyc(input logic [W-1:0] r, input logic [W-1:0] l, input logic e, input string tag);
    req = r;
    last = l;
    rr_en = e;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic cx(input logic [W-1:0] r, input logic [W-1:0] l, input logic e, input string tag, input logic [W-1:0] eg);
    cyc(r, l, e, tag);
    chk({tag, ".fixed"}, 32'(b0.grant), 32'(eg));
  endtask

  task automatic do_reset(input logic [W-1:0] r, input logic [W-1:0] l, input logic e, input string tag);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk({tag, ".rst_grant0"}, 32'(b0.grant), 0);
    chk({tag, ".rst_vld0"}, 32'(b0.grant_vld), 0);
    chk({tag, ".rst_id0"}, 32'(b0.grant_id), 0);
    chk({tag, ".rst_grant1"}, 32'(b1.grant), 0);
    req = r;
    last = l;
    rr_en = e;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    req = 4'hF;
    do_reset(4'hF, 4'h0, 1'b1, "t1");
    cx(4'b1010, 4'h0, 1'b1, "t1", 4'b0010);
    chk("t1.id", 32'(b0.grant_id), 1);
    do_reset(4'hF, 4'hF, 1'b1, "t2");
    cx(4'hF, 4'hF, 1'b1, "t2a", 4'b0001);
    cx(4'hF, 4'hF, 1'b1, "t2b", 4'b0010);
    cx(4'hF, 4'hF, 1'b1, "t2c", 4'b0100);
    cx(4'hF, 4'hF, 1'b1, "t2d", 4'b1000);
    cx(4'hF, 4'hF, 1'b1, "t2e", 4'b0001);
    do_reset(4'b0110, 4'hF, 1'b0, "t3");
    cx(4'b0110, 4'hF, 1'b0, "t3a", 4'b0010);
    cx(4'b0110, 4'hF, 1'b0, "t3b", 4'b0100);
    cx(4'b0110, 4'hF, 1'b0, "t3c", 4'b0010);
    cx(4'b0110, 4'hF, 1'b0, "t3d", 4'b0100);
    cx(4'b0011, 4'hF, 1'b0, "t3e", 4'b0001);
    cx(4'b0011, 4'hF, 1'b0, "t3f", 4'b0010);
    cx(4'b0011, 4'hF, 1'b0, "t3g", 4'b0001);
    do_reset(4'b0100, 4'h0, 1'b1, "t4");
    cx(4'b0100, 4'h0, 1'b1, "t4a", 4'b0100);
    cx(4'b0101, 4'h0, 1'b1, "t4b", 4'b0100);
    cx(4'b0101, 4'b0100, 1'b1, "t4c", 4'b0001);
    do_reset(4'b0010, 4'h0, 1'b1, "t5");
    cx(4'b0010, 4'h0, 1'b1, "t5a", 4'b0010);
    cx(4'b0010, 4'h0, 1'b1, "t5b", 4'b0010);
    cx(4'b0010, 4'h0, 1'b1, "t5c", 4'b0010);
    cx(4'b0010, 4'h0, 1'b1, "t5d", 4'b0010);
    cx(4'b0010, 4'h0, 1'b1, "t5e", 4'b0000);
    cx(4'b0010, 4'h0, 1'b1, "t5f", 4'b0010);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0010, 4'h0, 1'b1, "t5u");
      chk("t5.unlimited", 32'(b1.grant), 32'(4'b0010));
    end
    do_reset(4'b1100, 4'h0, 1'b1, "t6");
    cx(4'b1100, 4'h0, 1'b1, "t6a", 4'b0100);
    cx(4'b1100, 4'h0, 1'b1, "t6b", 4'b0100);
    cx(4'b1000, 4'h0, 1'b1, "t6c", 4'b1000);
    do_reset(4'hF, 4'h0, 1'b1, "t6r");
    cx(4'hF, 4'h0, 1'b1, "t6d", 4'b0001);
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 50) do_reset(4'($urandom), 4'h0, 1'b1, "rnd");
      cyc(4'($urandom), 4'($urandom) & 4'($urandom), ($urandom % 8) != 0, "rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
